// File: rtl/alu_rs_pkg.sv
// Shared definitions for the ALU reservation station: opcodes (shared with the ALU),
// ROB tag width, entry/operand records and the CDB snoop helper.
package alu_rs_pkg;
  localparam int ROB_TAG_W        = 5;
  localparam int RS_DEPTH_DEFAULT = 8;
  localparam int OP_W             = 7;

  localparam logic [OP_W-1:0] OP_NOP   = 7'd0;
  localparam logic [OP_W-1:0] OP_ADD   = 7'd1;
  localparam logic [OP_W-1:0] OP_SUB   = 7'd2;
  localparam logic [OP_W-1:0] OP_AND   = 7'd3;
  localparam logic [OP_W-1:0] OP_OR    = 7'd4;
  localparam logic [OP_W-1:0] OP_XOR   = 7'd5;
  localparam logic [OP_W-1:0] OP_SLL   = 7'd6;
  localparam logic [OP_W-1:0] OP_SRL   = 7'd7;
  localparam logic [OP_W-1:0] OP_SRA   = 7'd8;
  localparam logic [OP_W-1:0] OP_SLT   = 7'd9;
  localparam logic [OP_W-1:0] OP_SLTU  = 7'd10;
  localparam logic [OP_W-1:0] OP_ADDI  = 7'd11;
  localparam logic [OP_W-1:0] OP_BEQ   = 7'd12;
  localparam logic [OP_W-1:0] OP_BNE   = 7'd13;
  localparam logic [OP_W-1:0] OP_JAL   = 7'd14;
  localparam logic [OP_W-1:0] OP_JALR  = 7'd15;
  localparam logic [OP_W-1:0] OP_AUIPC = 7'd16;
  localparam logic [OP_W-1:0] OP_LUI   = 7'd17;

  typedef struct packed {
    logic                 qv;
    logic [ROB_TAG_W-1:0] q;
    logic [31:0]          v;
  } operand_t;

  typedef struct packed {
    logic [OP_W-1:0]      op;
    operand_t             oi;
    operand_t             oj;
    logic [31:0]          imm;
    logic [31:0]          pc;
    logic [ROB_TAG_W-1:0] rob;
  } ent_t;

  // The ALU port takes priority when both ports carry the same tag.
  function automatic operand_t snoop(input operand_t o,
                                     input logic av, input logic [ROB_TAG_W-1:0] at,
                                     input logic [31:0] ad,
                                     input logic lv, input logic [ROB_TAG_W-1:0] lt,
                                     input logic [31:0] ld);
    operand_t r;
    r = o;
    if (o.qv && av && o.q == at) begin
      r.qv = 1'b0;
      r.v  = ad;
    end else if (o.qv && lv && o.q == lt) begin
      r.qv = 1'b0;
      r.v  = ld;
    end
    return r;
  endfunction
endpackage

// File: rtl/alu_rs_select.sv
// Combinational picker: grants the requester with no older requester, where
// older_i[j][k] means k is older than j. A lower-triangular matrix gives lowest-index.
module alu_rs_select #(
  parameter int N = 8
) (
  input  logic [N-1:0]         req_i,
  input  logic [N-1:0][N-1:0]  older_i,
  output logic                 vld_o,
  output logic [$clog2(N)-1:0] idx_o
);
  logic [N-1:0] gnt;

  always_comb begin
    gnt   = '0;
    idx_o = '0;
    for (int j = 0; j < N; j++) begin
      gnt[j] = req_i[j] & ~|(req_i & older_i[j]);
      if (gnt[j]) idx_o = idx_o | ($clog2(N))'(j);
    end
  end

  assign vld_o = |req_i;
endmodule

// File: rtl/alu_rs.sv
// ALU reservation station: buffers issued ops, snoops both CDB ports, dispatches one
// ready op per cycle. ALU_RS_OLDEST_FIRST_EN selects age-ordered dispatch.
module alu_rs
  import alu_rs_pkg::*;
#(
  parameter int RS_DEPTH = RS_DEPTH_DEFAULT
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 rdy_in,
  input  logic                 flush_in,
  input  logic                 in_valid,
  input  logic [OP_W-1:0]      in_op,
  input  logic [31:0]          in_vi,
  input  logic [31:0]          in_vj,
  input  logic                 in_qi_valid,
  input  logic                 in_qj_valid,
  input  logic [ROB_TAG_W-1:0] in_qi,
  input  logic [ROB_TAG_W-1:0] in_qj,
  input  logic [31:0]          in_imm,
  input  logic [31:0]          in_pc,
  input  logic [ROB_TAG_W-1:0] in_rob,
  output logic                 full_out,
  input  logic                 cdb_alu_valid,
  input  logic [ROB_TAG_W-1:0] cdb_alu_rob,
  input  logic [31:0]          cdb_alu_val,
  input  logic                 cdb_lsb_valid,
  input  logic [ROB_TAG_W-1:0] cdb_lsb_rob,
  input  logic [31:0]          cdb_lsb_val,
  output logic [OP_W-1:0]      alu_op,
  output logic [31:0]          alu_vi,
  output logic [31:0]          alu_vj,
  output logic [31:0]          alu_imm,
  output logic [31:0]          alu_pc,
  output logic [ROB_TAG_W-1:0] alu_rd
);
  localparam int IW = $clog2(RS_DEPTH);

  logic [RS_DEPTH-1:0]               busy_q, busy_d, ready;
  ent_t                              ent_q [RS_DEPTH];
  ent_t                              ent_d [RS_DEPTH];
  ent_t                              disp;
  logic                              free_vld, disp_vld, alloc;
  logic [IW-1:0]                     free_idx, disp_idx;
  logic [RS_DEPTH-1:0][RS_DEPTH-1:0] lower_tri, pick_age;

  logic [OP_W-1:0]      op_q, op_d;
  logic [31:0]          vi_q, vi_d, vj_q, vj_d, imm_q, imm_d, pc_q, pc_d;
  logic [ROB_TAG_W-1:0] rd_q, rd_d;

  always_comb begin
    lower_tri = '0;
    ready     = '0;
    for (int r = 0; r < RS_DEPTH; r++) begin
      ready[r] = busy_q[r] & ~ent_q[r].oi.qv & ~ent_q[r].oj.qv;
      for (int c = 0; c < RS_DEPTH; c++) lower_tri[r][c] = (c < r);
    end
  end

  assign full_out = &busy_q;
  assign alloc    = in_valid & free_vld & ~flush_in;

  alu_rs_select #(.N(RS_DEPTH)) u_free (
    .req_i(~busy_q), .older_i(lower_tri), .vld_o(free_vld), .idx_o(free_idx)
  );
  alu_rs_select #(.N(RS_DEPTH)) u_disp (
    .req_i(ready), .older_i(pick_age), .vld_o(disp_vld), .idx_o(disp_idx)
  );

`ifdef ALU_RS_OLDEST_FIRST_EN
  logic [RS_DEPTH-1:0][RS_DEPTH-1:0] age_q, age_d;

  // Column clear drops stale "older" bits left by a previous occupant of the slot.
  always_comb begin
    age_d = age_q;
    if (alloc) begin
      for (int r = 0; r < RS_DEPTH; r++) age_d[r][free_idx] = 1'b0;
      age_d[free_idx] = busy_q;
    end
  end

  always_ff @(posedge clk_in or posedge rst_in)
    if (rst_in)      age_q <= '0;
    else if (rdy_in) age_q <= age_d;

  assign pick_age = age_q;
`else
  assign pick_age = lower_tri;
`endif

  always_comb begin
    busy_d = busy_q;
    ent_d  = ent_q;
    disp   = ent_q[disp_idx];
    op_d   = '0;
    vi_d   = vi_q;
    vj_d   = vj_q;
    imm_d  = imm_q;
    pc_d   = pc_q;
    rd_d   = rd_q;
    for (int i = 0; i < RS_DEPTH; i++) begin
      ent_d[i].oi = snoop(ent_q[i].oi, cdb_alu_valid, cdb_alu_rob, cdb_alu_val,
                          cdb_lsb_valid, cdb_lsb_rob, cdb_lsb_val);
      ent_d[i].oj = snoop(ent_q[i].oj, cdb_alu_valid, cdb_alu_rob, cdb_alu_val,
                          cdb_lsb_valid, cdb_lsb_rob, cdb_lsb_val);
    end
    if (disp_vld && !flush_in) begin
      busy_d[disp_idx] = 1'b0;
      op_d  = disp.op;
      vi_d  = disp.oi.v;
      vj_d  = disp.oj.v;
      imm_d = disp.imm;
      pc_d  = disp.pc;
      rd_d  = disp.rob;
    end
    if (alloc) begin
      busy_d[free_idx]    = 1'b1;
      ent_d[free_idx].op  = in_op;
      ent_d[free_idx].oi  = snoop('{qv: in_qi_valid, q: in_qi, v: in_vi},
                                  cdb_alu_valid, cdb_alu_rob, cdb_alu_val,
                                  cdb_lsb_valid, cdb_lsb_rob, cdb_lsb_val);
      ent_d[free_idx].oj  = snoop('{qv: in_qj_valid, q: in_qj, v: in_vj},
                                  cdb_alu_valid, cdb_alu_rob, cdb_alu_val,
                                  cdb_lsb_valid, cdb_lsb_rob, cdb_lsb_val);
      ent_d[free_idx].imm = in_imm;
      ent_d[free_idx].pc  = in_pc;
      ent_d[free_idx].rob = in_rob;
    end
    if (flush_in) busy_d = '0;
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      busy_q <= '0;
      for (int i = 0; i < RS_DEPTH; i++) ent_q[i] <= '0;
      op_q   <= '0;
      vi_q   <= '0;
      vj_q   <= '0;
      imm_q  <= '0;
      pc_q   <= '0;
      rd_q   <= '0;
    end else if (rdy_in) begin
      busy_q <= busy_d;
      ent_q  <= ent_d;
      op_q   <= op_d;
      vi_q   <= vi_d;
      vj_q   <= vj_d;
      imm_q  <= imm_d;
      pc_q   <= pc_d;
      rd_q   <= rd_d;
    end
  end

  assign alu_op  = op_q;
  assign alu_vi  = vi_q;
  assign alu_vj  = vj_q;
  assign alu_imm = imm_q;
  assign alu_pc  = pc_q;
  assign alu_rd  = rd_q;
endmodule
